mdu_ctrl: RTL and testbench

//  Iterative RV32M multiply/divide sequencer beside the EX-stage ALU. Accepts one
//  M-extension op, runs a 32-step shift-add multiply or restoring divide with sign
//  pre/post-fixup, and stalls the pipeline until done. Result muxes into EX writeback.

---
 rtl/mdu_if.sv | 24 ++
 rtl/mdu_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mdu_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mdu_if.sv
// Request/response bundle between the EX stage and the multiply/divide sequencer.
interface mdu_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [2:0]      opcode_i;
    logic [XLEN-1:0] op_a_i;
    logic [XLEN-1:0] op_b_i;
    logic            flush_i;
    logic            busy_o;
    logic            stall_o;
    logic            valid_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, opcode_i, op_a_i, op_b_i, flush_i,
        input  busy_o, stall_o, valid_o, result_o
    );

    modport slave (
        input  start_i, opcode_i, op_a_i, op_b_i, flush_i,
        output busy_o, stall_o, valid_o, result_o
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Iterative RV32M multiply/divide sequencer: 32-step shift-add multiply, restoring divide.
// Optional MDU_EARLY_OUT_EN: zero-operand multiplies and divide special cases finish in one cycle.
module mdu_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic clk_i,
    input  logic rst_i,
    mdu_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t           state_reg, state_next;
    logic [2:0]       op_reg;
    logic [XLEN-1:0]  hi_reg, lo_reg, b_reg, result_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             neg_reg, rem_neg_reg, div0_reg, busy_reg, valid_reg;

    logic             accept, is_div, a_signed, b_signed, sa, sb;
    logic [XLEN-1:0]  abs_a, abs_b;

    assign is_div = bus.opcode_i[2];
    assign accept = (state_reg == S_IDLE) && bus.start_i && !bus.flush_i;

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (bus.opcode_i)
            3'd1, 3'd4, 3'd6: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            3'd2:    a_signed = 1'b1;
            default: ;
        endcase
    end

    assign sa    = a_signed & bus.op_a_i[XLEN-1];
    assign sb    = b_signed & bus.op_b_i[XLEN-1];
    assign abs_a = sa ? -bus.op_a_i : bus.op_a_i;
    assign abs_b = sb ? -bus.op_b_i : bus.op_b_i;

    logic            early_take;
    logic [XLEN-1:0] early_res;
`ifdef MDU_EARLY_OUT_EN
    logic early_hit;
    always_comb begin
        early_hit = 1'b0;
        early_res = '0;
        if (is_div) begin
            if (bus.op_b_i == '0) begin
                early_hit = 1'b1;
                early_res = bus.opcode_i[1] ? bus.op_a_i : '1;
            end else if (!bus.opcode_i[0] && bus.op_a_i == MIN_NEG && bus.op_b_i == '1) begin
                early_hit = 1'b1;
                early_res = bus.opcode_i[1] ? '0 : MIN_NEG;
            end
        end else if (bus.op_a_i == '0 || bus.op_b_i == '0) begin
            early_hit = 1'b1;
        end
    end
    assign early_take = accept & early_hit;
`else
    assign early_take = 1'b0;
    assign early_res  = '0;
`endif

    // One iteration of each algorithm; hi/lo hold product or {remainder, quotient}.
    logic [XLEN:0]   mul_sum, rem_sh;
    logic [XLEN-1:0] rem_sub;
    logic            rem_ge;
    always_comb begin
        mul_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : {(XLEN+1){1'b0}});
        rem_sh  = {hi_reg, lo_reg[XLEN-1]};
        rem_ge  = rem_sh >= {1'b0, b_reg};
        rem_sub = rem_sh[XLEN-1:0] - b_reg;
    end

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;
    always_comb begin
        prod_fix = neg_reg ? -{hi_reg, lo_reg} : {hi_reg, lo_reg};
        // Divide-by-zero quotient is all ones regardless of sign; the remainder already equals op_a.
        quo_fix  = div0_reg ? '1 : (neg_reg ? -lo_reg : lo_reg);
        rem_fix  = rem_neg_reg ? -hi_reg : hi_reg;
        case (op_reg)
            3'd0:             fix_res = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3: fix_res = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:       fix_res = quo_fix;
            default:          fix_res = rem_fix;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (accept) state_next = early_take ? S_DONE : S_CALC;
            S_CALC: begin
                if (bus.flush_i)                          state_next = S_IDLE;
                else if (cnt_reg == CNT_W'(XLEN - 1))     state_next = S_FIX;
            end
            S_FIX:   state_next = bus.flush_i ? S_IDLE : S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next == S_CALC) || (state_next == S_FIX);
            valid_reg <= (state_next == S_DONE);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_reg      <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            b_reg       <= '0;
            cnt_reg     <= '0;
            neg_reg     <= 1'b0;
            rem_neg_reg <= 1'b0;
            div0_reg    <= 1'b0;
            result_reg  <= '0;
        end else begin
            case (state_reg)
                S_IDLE: if (accept) begin
                    op_reg      <= bus.opcode_i;
                    cnt_reg     <= '0;
                    neg_reg     <= sa ^ sb;
                    rem_neg_reg <= sa;
                    div0_reg    <= (bus.op_b_i == '0);
                    hi_reg      <= '0;
                    lo_reg      <= is_div ? abs_a : abs_b;
                    b_reg       <= is_div ? abs_b : abs_a;
                    if (early_take) result_reg <= early_res;
                end
                S_CALC: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (op_reg[2]) begin
                        hi_reg <= rem_ge ? rem_sub : rem_sh[XLEN-1:0];
                        lo_reg <= {lo_reg[XLEN-2:0], rem_ge};
                    end else begin
                        hi_reg <= mul_sum[XLEN:1];
                        lo_reg <= {mul_sum[0], lo_reg[XLEN-1:1]};
                    end
                end
                S_FIX: if (!bus.flush_i) result_reg <= fix_res;
                default: ;
            endcase
        end
    end

    assign bus.busy_o   = busy_reg;
    assign bus.valid_o  = valid_reg;
    assign bus.result_o = result_reg;
    assign bus.stall_o  = accept | busy_reg;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed RV32M cases, flush/reset aborts, random ops vs. arithmetic model.
module tb_mdu_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    mdu_if bus ();
    mdu_ctrl dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // RISC-V M-extension results computed with wide integer arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      as_l, bs_l, au_l, bu_l;
        logic [63:0] p;
        logic        ovf;
        as_l = longint'($signed(a));
        bs_l = longint'($signed(b));
        au_l = longint'({32'b0, a});
        bu_l = longint'({32'b0, b});
        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p    = '0;
        case (op)
            3'd0: begin p = as_l * bs_l; return p[31:0];  end
            3'd1: begin p = as_l * bs_l; return p[63:32]; end
            3'd2: begin p = as_l * bu_l; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return 32'h8000_0000;
                p = as_l / bs_l; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = au_l / bu_l; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf)    return 32'h0;
                p = as_l % bs_l; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = au_l % bu_l; return p[31:0];
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_EARLY_OUT_EN
        logic special;
        if (op[2]) special = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        else       special = (a == 0) || (b == 0);
        return special ? 1 : 34;
`else
        return 34;
`endif
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit hold);
        logic [31:0] exp_res;
        int          exp_lat, lat;
        bit          seen, prof_ok;
        logic [31:0] got;
        exp_res = ref_result(op, a, b);
        exp_lat = ref_latency(op, a, b);
        @(negedge clk);
        bus.start_i  = 1'b1;
        bus.opcode_i = op;
        bus.op_a_i   = a;
        bus.op_b_i   = b;
        #1;
        chk("stall_cycle0", {31'b0, bus.stall_o}, 32'd1);
        lat = 0; seen = 1'b0; prof_ok = 1'b1; got = 'x;
        while (!seen && lat < 60) begin
            @(negedge clk);
            lat++;
            if (bus.valid_o === 1'b1) begin
                seen = 1'b1;
                got  = bus.result_o;
                if (bus.busy_o !== 1'b0 || bus.stall_o !== 1'b0) prof_ok = 1'b0;
            end else if (bus.busy_o !== 1'b1 || bus.stall_o !== 1'b1) begin
                prof_ok = 1'b0;
            end
            if (!hold) bus.start_i = 1'b0;
            bus.op_a_i = $urandom;
            bus.op_b_i = $urandom;
        end
        bus.start_i = 1'b0;
        chk("latency", lat, exp_lat);
        chk("result", got, exp_res);
        chk("busy_stall_profile", {31'b0, prof_ok}, 32'd1);
        @(negedge clk);
        chk("valid_pulse_busy_after", {30'b0, bus.valid_o, bus.busy_o}, 32'd0);
        chk("result_held", bus.result_o, exp_res);
        $display("op=%0d a=%h b=%h result=%h expect=%h latency=%0d", op, a, b, got, exp_res, lat);
    endtask

    logic [2:0]  d_op [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] d_a  [12] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                               32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'hFFFF_FFF9,
                               32'h8000_0000, 32'h8000_0000};
    logic [31:0] d_b  [12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                               32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    initial begin
        logic [31:0] prev;
        bit          any_valid;
        logic [2:0]  r_op;
        logic [31:0] r_a, r_b;
        bus.start_i = 1'b0; bus.opcode_i = '0; bus.op_a_i = '0; bus.op_b_i = '0; bus.flush_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {29'b0, bus.busy_o, bus.valid_o, bus.stall_o}, 32'd0);
        chk("reset_result", bus.result_o, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_op(d_op[i], d_a[i], d_b[i], 1'b0);

        // Flush at cycle 10 of a divide, then a fresh op launched at cycle 12.
        prev = bus.result_o;
        any_valid = 1'b0;
        @(negedge clk);
        bus.start_i = 1'b1; bus.opcode_i = 3'd5; bus.op_a_i = 32'd1000; bus.op_b_i = 32'd3;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
            if (bus.valid_o === 1'b1) any_valid = 1'b1;
            if (c == 10) bus.flush_i = 1'b1;
            if (c == 11) begin
                chk("flush_idle", {30'b0, bus.busy_o, bus.stall_o}, 32'd0);
                chk("flush_result_kept", bus.result_o, prev);
                bus.flush_i = 1'b0;
            end
        end
        chk("flush_no_valid", {31'b0, any_valid}, 32'd0);
        $display("op=5 a=%h b=%h flushed at cycle 10", 32'd1000, 32'd3);
        run_op(3'd5, 32'd1000, 32'd3, 1'b0);

        // Start held high through the whole op: exactly one op runs.
        run_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);

        // Synchronous reset in the middle of a multiply.
        any_valid = 1'b0;
        @(negedge clk);
        bus.start_i = 1'b1; bus.opcode_i = 3'd0; bus.op_a_i = 32'd3; bus.op_b_i = 32'd5;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
            if (bus.valid_o === 1'b1) any_valid = 1'b1;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy_valid", {30'b0, bus.busy_o, bus.valid_o}, 32'd0);
        chk("rst_result", bus.result_o, 32'd0);
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.valid_o === 1'b1) any_valid = 1'b1;
        end
        chk("rst_no_valid", {31'b0, any_valid}, 32'd0);
        $display("op=0 a=%h b=%h reset at cycle 20", 32'd3, 32'd5);

        for (int i = 0; i < 40; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            r_b  = $urandom;
            case ($urandom_range(0, 9))
                0: r_b = '0;
                1: r_a = '0;
                2: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
                3: r_b = 32'($urandom_range(1, 20));
                default: ;
            endcase
            run_op(r_op, r_a, r_b, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
